// File: rtl/divider_pkg.sv
// Shared definitions for the sequential arithmetic blocks (divider and shift-add multiplier):
// FSM encodings and the ready decode that both blocks use for the trigger/ready/done handshake.
package divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'h0,
    ST_CAL  = 2'h1,
    ST_DONE = 2'h2
  } state_e;

  // A new trigger can be taken while idle or during the done cycle, which allows back-to-back work.
  function automatic logic is_ready_state(input state_e s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/divider_if.sv
// Operand/result bundle for the divider, plus a debug view of the control FSM state.
interface divider_if
  import divider_pkg::*;
#(
  parameter int C_WIDTH = 32
) ();

  // Handshake: a start is taken on a rising edge where trigger=1 and ready=1; the operands
  // are sampled on that edge. trigger while ready=0 is dropped, never queued. done pulses
  // for one cycle when quotient/remainder/div_by_zero become valid; results then hold.
  logic [C_WIDTH-1:0] dividend;
  logic [C_WIDTH-1:0] divisor;
  logic               trigger;
  logic [C_WIDTH-1:0] quotient;
  logic [C_WIDTH-1:0] remainder;
  logic               ready;
  logic               done;
  logic               div_by_zero;
  state_e             state_dbg;

  modport master (
    output dividend, divisor, trigger,
    input  quotient, remainder, ready, done, div_by_zero, state_dbg
  );

  modport slave (
    input  dividend, divisor, trigger,
    output quotient, remainder, ready, done, div_by_zero, state_dbg
  );

endinterface

// File: rtl/divider_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module divider_div_step #(
  parameter int C_WIDTH = 32
) (
  input  logic [C_WIDTH:0]   r_i,
  input  logic               q_msb_i,
  input  logic [C_WIDTH-1:0] divisor_i,
  output logic [C_WIDTH:0]   r_next_o,
  output logic               q_bit_o
);

  logic [C_WIDTH:0] shifted;
  logic [C_WIDTH:0] diff;

  // r_i[C_WIDTH] is zero whenever the partial remainder is below the divisor; it still
  // forces a subtract so the step stays correct if that invariant is ever broken upstream.
  assign shifted  = {r_i[C_WIDTH-1:0], q_msb_i};
  assign diff     = shifted - {1'b0, divisor_i};
  assign q_bit_o  = r_i[C_WIDTH] | (shifted >= {1'b0, divisor_i});
  assign r_next_o = q_bit_o ? diff : shifted;

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, trigger/ready/done handshake.
// Divide by zero short-cuts to done one cycle after the start with all-ones quotient.
module divider
  import divider_pkg::*;
#(
  parameter int C_WIDTH = 32
) (
  input  logic    ctl_clk,
  input  logic    reset,
  divider_if.slave bus
);

  localparam int CW = (C_WIDTH > 1) ? $clog2(C_WIDTH) : 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [C_WIDTH-1:0] divisor_q, divisor_d;
  logic [C_WIDTH-1:0] work_q_q, work_q_d;
  logic [C_WIDTH:0]   work_r_q, work_r_d;
  logic [C_WIDTH-1:0] quotient_q, quotient_d;
  logic [C_WIDTH-1:0] remainder_q, remainder_d;
  logic               dbz_q, dbz_d;

  logic               ready;
  logic               accept;
  logic [C_WIDTH:0]   step_r;
  logic               step_bit;
  logic [C_WIDTH-1:0] step_q;

  divider_div_step #(.C_WIDTH(C_WIDTH)) u_step (
    .r_i       (work_r_q),
    .q_msb_i   (work_q_q[C_WIDTH-1]),
    .divisor_i (divisor_q),
    .r_next_o  (step_r),
    .q_bit_o   (step_bit)
  );

  assign step_q = {work_q_q[C_WIDTH-2:0], step_bit};
  assign ready  = reset && is_ready_state(state_q);
  assign accept = ready && bus.trigger;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    divisor_d   = divisor_q;
    work_q_d    = work_q_q;
    work_r_d    = work_r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          divisor_d = bus.divisor;
          work_q_d  = bus.dividend;
          work_r_d  = '0;
          count_d   = '0;
          dbz_d     = 1'b0;
          if (bus.divisor == '0) begin
            state_d     = ST_DONE;
            quotient_d  = '1;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = ST_CAL;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAL: begin
        work_r_d = step_r;
        work_q_d = step_q;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(C_WIDTH - 1)) begin
          state_d     = ST_DONE;
          quotient_d  = step_q;
          remainder_d = step_r[C_WIDTH-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      divisor_q   <= '0;
      work_q_q    <= '0;
      work_r_q    <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      divisor_q   <= divisor_d;
      work_q_q    <= work_q_d;
      work_r_q    <= work_r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.ready       = ready;
  assign bus.done        = (state_q == ST_DONE);
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_divider.sv
// Bench for the restoring divider: directed vectors with literal expectations, plus an
// arithmetic reference model feeding an expected queue that is checked on every done pulse.
module tb_divider;
  import divider_pkg::*;

  localparam int W = 32;
  localparam int LAT_NORMAL = W + 1;
  localparam int LAT_ZERO   = 1;

  logic ctl_clk = 1'b0;
  logic reset   = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [2*W:0] exp_q[$];
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  always #5 ctl_clk = ~ctl_clk;

  divider_if #(.C_WIDTH(W)) bus ();

  divider #(.C_WIDTH(W)) dut (
    .ctl_clk (ctl_clk),
    .reset   (reset),
    .bus     (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, with the all-ones / dividend convention for b == 0.
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return {{W{1'b1}}, a, 1'b1};
    return {a / b, a % b, 1'b0};
  endfunction

  // Compare process: checks every done pulse against the queue and that results hold otherwise.
  initial begin
    logic [2*W:0] e;
    forever begin
      @(negedge ctl_clk);
      if (!reset) begin
        last_q = '0;
        last_r = '0;
      end else if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {63'b0, bus.done}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_quotient", bus.quotient, e[2*W:W+1]);
          check("sb_remainder", bus.remainder, e[W:1]);
          check("sb_div_by_zero", {63'b0, bus.div_by_zero}, {63'b0, e[0]});
        end
        last_q = bus.quotient;
        last_r = bus.remainder;
      end else begin
        check("hold_quotient", bus.quotient, last_q);
        check("hold_remainder", bus.remainder, last_r);
      end
    end
  end

  // Drives one operation; trigger stays high for 'hold' cycles with scrambled operands after
  // the first edge. Returns edges from trigger until done is seen, and the results at done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                        output int lat, output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic z);
    int w;
    w = 0;
    @(negedge ctl_clk);
    while (!bus.ready && w < 100) begin
      @(negedge ctl_clk);
      w++;
    end
    check("ready_before_start", {63'b0, bus.ready}, 64'd1);
    bus.dividend = a;
    bus.divisor  = b;
    bus.trigger  = 1'b1;
    exp_q.push_back(model(a, b));
    lat = 0;
    do begin
      @(posedge ctl_clk);
      #1;
      lat++;
      if (lat >= hold) begin
        bus.trigger = 1'b0;
      end else begin
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
      end
      if (hold > 5 && lat == 5) check("ready_low_in_cal", {63'b0, bus.ready}, 64'd0);
    end while (!bus.done && lat < 100);
    check("done_seen", {63'b0, bus.done}, 64'd1);
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic ez, input int elat);
    int lat;
    logic [W-1:0] q, r;
    logic z;
    run_op(a, b, hold, lat, q, r, z);
    check({name, "_latency"}, 64'(lat), 64'(elat));
    check({name, "_q"}, q, eq);
    check({name, "_r"}, r, er);
    check({name, "_dbz"}, {63'b0, z}, {63'b0, ez});
  endtask

  initial begin
    int lat, nd;
    logic [W-1:0] q, r, a, b;
    logic z;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.trigger  = 1'b0;
    #1;
    check("rst_quotient", bus.quotient, 64'd0);
    check("rst_remainder", bus.remainder, 64'd0);
    check("rst_done", {63'b0, bus.done}, 64'd0);
    check("rst_dbz", {63'b0, bus.div_by_zero}, 64'd0);
    check("rst_ready", {63'b0, bus.ready}, 64'd0);
    repeat (2) @(negedge ctl_clk);
    reset = 1'b1;
    #1;
    check("ready_after_rst", {63'b0, bus.ready}, 64'd1);

    directed("basic",    32'd100,      32'd7,        1, 32'd14,       32'd2,      1'b0, LAT_NORMAL);
    directed("zero_div", 32'h1234,     32'd0,        1, 32'hFFFFFFFF, 32'h1234,   1'b1, LAT_ZERO);
    directed("max_by_1", 32'hFFFFFFFF, 32'd1,        1, 32'hFFFFFFFF, 32'd0,      1'b0, LAT_NORMAL);
    directed("small",    32'd5,        32'd9,        1, 32'd0,        32'd5,      1'b0, LAT_NORMAL);
    directed("zero_num", 32'd0,        32'd3,        1, 32'd0,        32'd0,      1'b0, LAT_NORMAL);
    directed("max_max",  32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'd1,        32'd0,      1'b0, LAT_NORMAL);
    directed("b2b",      32'd1000,     32'd10,       1, 32'd100,      32'd0,      1'b0, LAT_NORMAL);
    directed("held_trig",32'd500,      32'd3,       20, 32'd166,      32'd2,      1'b0, LAT_NORMAL);
    directed("zz_first", 32'd77,       32'd0,        1, 32'hFFFFFFFF, 32'd77,     1'b1, LAT_ZERO);
    directed("zz_second",32'd9,        32'd0,        1, 32'hFFFFFFFF, 32'd9,      1'b1, LAT_ZERO);

    // Abort ten steps into a calculation; the aborted result must never appear.
    @(negedge ctl_clk);
    @(negedge ctl_clk);
    bus.dividend = 32'd1234567;
    bus.divisor  = 32'd89;
    bus.trigger  = 1'b1;
    @(posedge ctl_clk);
    #1;
    bus.trigger = 1'b0;
    repeat (10) @(posedge ctl_clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_quotient", bus.quotient, 64'd0);
    check("abort_remainder", bus.remainder, 64'd0);
    check("abort_done", {63'b0, bus.done}, 64'd0);
    check("abort_dbz", {63'b0, bus.div_by_zero}, 64'd0);
    check("abort_ready", {63'b0, bus.ready}, 64'd0);
    repeat (3) @(negedge ctl_clk);
    reset = 1'b1;
    #1;
    check("abort_ready_release", {63'b0, bus.ready}, 64'd1);
    nd = 0;
    repeat (40) begin
      @(negedge ctl_clk);
      if (bus.done) nd++;
    end
    check("abort_no_done", 64'(nd), 64'd0);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      if ($urandom_range(0, 19) == 0) b = '0;
      else if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 255));
      else b = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 1000));
      if ($urandom_range(0, 1) == 0) @(negedge ctl_clk);
      run_op(a, b, 1, lat, q, r, z);
      check("rand_latency", 64'(lat), 64'((b == '0) ? LAT_ZERO : LAT_NORMAL));
    end

    repeat (3) @(negedge ctl_clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
